// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared defaults, FSM state encoding and MULT cycle count for the element-wise multiplier
package matrix_pkg;

    localparam int DEF_DW      = 16;
    localparam int DEF_N_ELEM  = 9;
    // One multiplier bit is consumed per MULT cycle, so an element takes DW cycles.
    localparam int MULT_CYCLES = DEF_DW;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MULT  = 2'd1,
        ST_STORE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/shift_add_mult.sv
// rtl/shift_add_mult.sv - sequential unsigned shift-add multiplier, one multiplier bit per step
module shift_add_mult
    import matrix_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic            i_step,
    input  logic [DW-1:0]   i_a,
    input  logic [DW-1:0]   i_b,
    output logic [2*DW-1:0] o_product
);

    logic [2*DW-1:0] r_mcand;
    logic [DW-1:0]   r_mplier;
    logic [2*DW-1:0] r_prod;

    // Load clears the accumulator; each step adds the shifted multiplicand when the current multiplier LSB is set.
    // No early exit: a zero operand still takes all DW steps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
        end else if (i_load) begin
            r_mcand  <= {{DW{1'b0}}, i_a};
            r_mplier <= i_b;
            r_prod   <= '0;
        end else if (i_step) begin
            if (r_mplier[0]) begin
                r_prod <= r_prod + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

    assign o_product = r_prod;

endmodule

// File: rtl/matrix_elementwise_mult_seq.sv
// rtl/matrix_elementwise_mult_seq.sv - 3x3 element-wise multiplier, one element at a time; MATMUL_OVF_EN adds per-element overflow flags
module matrix_elementwise_mult_seq
    import matrix_pkg::*;
#(
    parameter int DW     = DEF_DW,
    parameter int N_ELEM = DEF_N_ELEM
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [N_ELEM*DW-1:0] mat0,
    input  logic [N_ELEM*DW-1:0] mat1,
    output logic [N_ELEM*DW-1:0] result,
    output logic                 busy,
    output logic                 done
`ifdef MATMUL_OVF_EN
    ,
    output logic [N_ELEM-1:0]    ovf
`endif
);

    localparam int STEPS = (DW == DEF_DW) ? MULT_CYCLES : DW;
    localparam int CW    = $clog2(STEPS + 1);
    localparam int IW    = $clog2(N_ELEM + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STEPS - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_ELEM - 1);

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [IW-1:0]         r_idx;
    logic [N_ELEM*DW-1:0]  r_mat0;
    logic [N_ELEM*DW-1:0]  r_mat1;
    logic [N_ELEM*DW-1:0]  r_result;

    logic                  w_load;
    logic                  w_step;
    logic [DW-1:0]         w_a;
    logic [DW-1:0]         w_b;
    logic [IW-1:0]         w_nidx;
    logic [2*DW-1:0]       w_product;

    assign w_nidx = r_idx + 1'b1;
    assign w_step = (r_state == ST_MULT);

    // Multiplier load: element 0 comes straight from the ports on the accepting edge,
    // later elements from the latched operands on the STORE edge of the previous one.
    always_comb begin
        w_load = 1'b0;
        w_a    = mat0[DW-1:0];
        w_b    = mat1[DW-1:0];
        if (r_state == ST_IDLE) begin
            w_load = start;
        end else if ((r_state == ST_STORE) && (r_idx != IDX_LAST)) begin
            w_load = 1'b1;
            w_a    = r_mat0[w_nidx*DW +: DW];
            w_b    = r_mat1[w_nidx*DW +: DW];
        end
    end

    shift_add_mult #(
        .DW        (DW)
    ) u_mult (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_load),
        .i_step    (w_step),
        .i_a       (w_a),
        .i_b       (w_b),
        .o_product (w_product)
    );

`ifdef MATMUL_OVF_EN
    logic [N_ELEM-1:0] r_ovf;

    // Overflow flag per element: cleared when an operation is accepted, written when its product is stored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= '0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_ovf <= '0;
        end else if (r_state == ST_STORE) begin
            r_ovf[r_idx] <= |w_product[2*DW-1:DW];
        end
    end

    assign ovf = r_ovf;
`else
    logic w_unused_hi;
    assign w_unused_hi = |w_product[2*DW-1:DW];
`endif

    // Sequencer: IDLE -> (MULT x STEPS -> STORE) per element -> DONE -> IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_mat0   <= '0;
            r_mat1   <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mat0  <= mat0;
                        r_mat1  <= mat1;
                        r_idx   <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_MULT;
                    end
                end
                ST_MULT: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_STORE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_STORE: begin
                    r_result[r_idx*DW +: DW] <= w_product[DW-1:0];
                    if (r_idx == IDX_LAST) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_idx   <= w_nidx;
                        r_state <= ST_MULT;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign result = r_result;
    assign busy   = (r_state != ST_IDLE);
    assign done   = (r_state == ST_DONE);

endmodule

// File: doc/matrix_elementwise_mult_seq.md
MATRIX_ELEMENTWISE_MULT_SEQ -- requirements
Module: matrix_elementwise_mult_seq

Interface
REQ-001 SHALL have parameter DW, default 16, the element width in bits.
REQ-002 SHALL have parameter N_ELEM, default 9, the element count (3x3 matrix, row-major a..i).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request to multiply; accepted only in IDLE.
REQ-006 SHALL have port mat0, input, N_ELEM*DW bits: first operand matrix; element k at bits [k*DW +: DW], k=0 is element a.
REQ-007 SHALL have port mat1, input, N_ELEM*DW bits: second operand matrix, same layout as mat0.
REQ-008 SHALL have port result, output, N_ELEM*DW bits: element-wise products, low DW bits, same layout.
REQ-009 SHALL have port busy, output, 1 bit: high from the edge that accepts start until the DONE state is left.
REQ-010 SHALL have port done, output, 1 bit: single-cycle pulse when all elements are stored.
REQ-011 SHALL have port ovf, output, N_ELEM bits, present only under MATMUL_OVF_EN: per-element overflow flag.

Function
REQ-012 SHALL implement an FSM with states IDLE, MULT, STORE and DONE.
REQ-013 SHALL, on an edge in IDLE with start=1, latch mat0 and mat1 into internal registers, set element index to 0, go to MULT and raise busy; the edge that accepts start is edge 0.
REQ-014 SHALL ignore mat0, mat1 and start changes while busy; a start that is not accepted is dropped and not queued.
REQ-015 SHALL, in MULT, perform unsigned shift-add multiplication, one multiplier bit per cycle, taking exactly DW cycles per element.
REQ-016 SHALL, in STORE (1 cycle), write the low DW bits of the 2*DW-bit product to result element k, then advance k, or go to DONE if k = N_ELEM-1.
REQ-017 SHALL, for element e, execute MULT on edges 17e+1..17e+16 and STORE on edge 17e+17 (DW=16).
REQ-018 SHALL assert done for exactly one cycle, in DONE (reached at edge 154 for the defaults), then return to IDLE with busy=0.
REQ-019 SHALL hold result elements not yet rewritten at their previous values during an operation; result is valid as a whole only while done=1 and after it.
REQ-020 SHALL accept start again in the cycle after DONE (back-to-back operations allowed).
REQ-021 SHALL produce a 0 product in exactly DW cycles when either operand is 0 (no early termination).

Reset
REQ-022 SHALL, when rst_n=0 at any time, including mid-operation, immediately force state to IDLE and clear busy, done, result, ovf, operand registers and the index to 0.
REQ-023 SHALL need a fresh start after reset is released; no partial operation resumes.

Configuration
REQ-024 SHALL, with MATMUL_OVF_EN defined, provide ovf; ovf[k] is written in STORE to 1 iff the upper DW bits of product k are nonzero, is cleared on start acceptance, and resets to 0.
REQ-025 SHALL, without MATMUL_OVF_EN, have no ovf port and no overflow logic; all other behaviour is identical.

Structure
REQ-026 SHALL place DW and N_ELEM defaults, the FSM state enum and the MULT cycle constant in shared package matrix_pkg.
REQ-027 SHALL put the per-element sequential shift-add datapath in one sub-module, shift_add_mult, with load/step inputs and a 2*DW-bit product output; the top block holds the FSM, the index counter and the result registers.

Verification
REQ-028 Basic: mat0 = {128,16,128,8,2,1,2,16,2}, mat1 = {4,2,1,1,1,1,4,512,2}, start for 1 cycle -> done at edge 154; result = {512,32,128,8,2,1,8,8192,4}; ovf = 0.
REQ-029 Overflow: element a = 300 x 300, all other elements 0 -> result a = 24464, others 0; with MATMUL_OVF_EN, ovf = 9'b000000001.
REQ-030 Busy protection: start pulse at edge 50 with different operands -> ignored; done still at edge 154 with the original results.
REQ-031 Reset mid-operation: rst_n low at edge 80 -> result, busy, done and ovf become 0 at once; no done pulse follows until a new start.
REQ-032 Back-to-back: start held high through DONE -> second operation accepted on the edge after DONE; second done 155 edges after the first.
REQ-033 Extremes: 65535 x 65535 -> result 1, ovf 1; 0 x 65535 -> result 0, still 16 MULT cycles.
